// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_MIN  = 2'b01,
        MODE_SET_HORA = 2'b10,
        MODE_ALT_RUN  = 2'b11
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ZERO  = 7'b1111110;

    // The unused encoding behaves exactly like normal running display.
    function automatic mode_t normMode(input mode_t m);
        return (m == MODE_ALT_RUN) ? MODE_RUN : m;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot divider, digit index, frame counter and blink phase for the display scanner.
module scan_timer #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 125,
    parameter int DIV_W        = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DIV_W-1:0] o_divCnt,
    output logic [1:0]       o_idx,
    output logic             o_blinkPh,
    output logic             o_frameEnd
);

    localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]   r_divCnt;
    logic [1:0]         r_idx;
    logic [FRAME_W-1:0] r_frameCnt;
    logic               r_blinkPh;
    logic               w_slotEnd;
    logic               w_frameEnd;

    assign w_slotEnd  = (r_divCnt == DIV_LAST);
    assign w_frameEnd = w_slotEnd && (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_divCnt   <= '0;
            r_idx      <= '0;
            r_frameCnt <= '0;
            r_blinkPh  <= 1'b0;
        end else begin
            if (w_slotEnd) begin
                r_divCnt <= '0;
                r_idx    <= r_idx + 2'd1;
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
            // Blink phase flips once every BLINK_FRAMES completed frames.
            if (w_frameEnd) begin
                if (r_frameCnt == FRAME_LAST) begin
                    r_frameCnt <= '0;
                    r_blinkPh  <= ~r_blinkPh;
                end else begin
                    r_frameCnt <= r_frameCnt + FRAME_W'(1);
                end
            end
        end
    end

    assign o_divCnt   = r_divCnt;
    assign o_idx      = r_idx;
    assign o_blinkPh  = r_blinkPh;
    assign o_frameEnd = w_frameEnd;

endmodule

// File: rtl/display_scan.sv
// Time-multiplexes four digit patterns onto one segment bus with blinking,
// leading-zero blanking and the colon dot; all outputs registered.
module display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter int DEAD           = 2,
    parameter int BLINK_FRAMES   = 125,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dig0,
    input  logic [6:0] dig1,
    input  logic [6:0] dig2,
    input  logic [6:0] dig3,
    input  logic [1:0] modo,
    input  logic       dp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DEAD_CNT = DIV_W'(DEAD);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic LZ_EN   = (LZ_BLANK != 0);

    logic [DIV_W-1:0] w_divCnt;
    logic [1:0]       w_idx;
    logic             w_blinkPh;
    logic             w_frameEnd;

    logic [6:0] r_shDig [0:3];
    mode_t      r_shMode;
    logic       r_shDp;

    mode_t      w_mode;
    logic       w_enActive;
    logic [3:0] w_anOneHot;
    logic       w_blinkBlank;
    logic       w_lzBlank;
    logic [6:0] w_segRaw;
    logic       w_dpRaw;

    logic [6:0] r_seg;
    logic       r_dp;
    logic [3:0] r_an;

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .DIV_W        (DIV_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .o_divCnt   (w_divCnt),
        .o_idx      (w_idx),
        .o_blinkPh  (w_blinkPh),
        .o_frameEnd (w_frameEnd)
    );

    // Inputs are sampled only at frame boundaries so a frame never tears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shDig[0] <= SEG_BLANK;
            r_shDig[1] <= SEG_BLANK;
            r_shDig[2] <= SEG_BLANK;
            r_shDig[3] <= SEG_BLANK;
            r_shMode   <= MODE_RUN;
            r_shDp     <= 1'b0;
        end else if (w_frameEnd) begin
            r_shDig[0] <= dig0;
            r_shDig[1] <= dig1;
            r_shDig[2] <= dig2;
            r_shDig[3] <= dig3;
            r_shMode   <= mode_t'(modo);
            r_shDp     <= dp_en;
        end
    end

    assign w_mode       = normMode(r_shMode);
    assign w_enActive   = (w_divCnt >= DEAD_CNT);
    assign w_anOneHot   = w_enActive ? (4'b0001 << w_idx) : 4'b0000;
    assign w_blinkBlank = w_blinkPh &&
                          (((w_mode == MODE_SET_MIN)  && !w_idx[1]) ||
                           ((w_mode == MODE_SET_HORA) &&  w_idx[1]));
    // An hour-tens zero stays visible while hours are being edited.
    assign w_lzBlank    = LZ_EN && (w_idx == 2'd3) &&
                          (r_shDig[3] == SEG_ZERO) && (w_mode != MODE_SET_HORA);
    assign w_segRaw     = (w_blinkBlank || w_lzBlank) ? SEG_BLANK : r_shDig[w_idx];
    assign w_dpRaw      = (w_idx == 2'd2) && r_shDp && w_enActive;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seg <= {7{SEG_INV}};
            r_dp  <= SEG_INV;
            r_an  <= {4{AN_INV}};
        end else begin
            r_seg <= w_segRaw ^ {7{SEG_INV}};
            r_dp  <= w_dpRaw ^ SEG_INV;
            r_an  <= w_anOneHot ^ {4{AN_INV}};
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a frame-arithmetic model predicts every output cycle.
module tb_display_scan;
    import display_pkg::*;

    localparam int RDIV  = 4;
    localparam int DEADC = 1;
    localparam int BFR   = 2;
    localparam int FRAME = 4 * RDIV;

    localparam logic [6:0] PAT1 = 7'b0110000;
    localparam logic [6:0] PAT2 = 7'b1101101;
    localparam logic [6:0] PAT3 = 7'b1111001;
    localparam logic [6:0] PAT4 = 7'b0110011;
    localparam logic [6:0] PAT7 = 7'b1110000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] digIn [0:3];
    logic [1:0] modo;
    logic       dpEn;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    logic [11:0] expQ [$];
    int          mN = 0;
    logic [6:0]  mDig [0:3];
    logic [1:0]  mMode = 2'b00;
    logic        mDp   = 1'b0;

    display_scan #(
        .REFRESH_DIV    (RDIV),
        .DEAD           (DEADC),
        .BLINK_FRAMES   (BFR),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1),
        .LZ_BLANK       (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dig0  (digIn[0]),
        .dig1  (digIn[1]),
        .dig2  (digIn[2]),
        .dig3  (digIn[3]),
        .modo  (modo),
        .dp_en (dpEn),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Expected {an, seg, dp} one edge after the model state held in mN / shadow copies.
    function automatic logic [11:0] modelOut();
        int div, idx, frame;
        logic ph, blank, d;
        logic [1:0] md;
        logic [3:0] anA;
        logic [6:0] s;
        if (!rst) return {4'hF, 7'h7F, 1'b1};
        div   = mN % RDIV;
        idx   = (mN / RDIV) % 4;
        frame = mN / FRAME;
        ph    = ((frame / BFR) % 2) == 1;
        md    = (mMode == 2'b11) ? 2'b00 : mMode;
        anA   = (div >= DEADC) ? 4'(1 << idx) : 4'h0;
        blank = (ph && md == 2'b01 && idx < 2) ||
                (ph && md == 2'b10 && idx >= 2) ||
                (idx == 3 && mDig[3] == SEG_ZERO && md != 2'b10);
        s     = blank ? 7'h00 : mDig[idx];
        d     = (idx == 2) && mDp && (anA != 4'h0);
        return {~anA, ~s, ~d};
    endfunction

    task automatic applyStimulus(input int cycles);
        logic [11:0] got;
        repeat (cycles) begin
            expQ.push_back(modelOut());
            if (!rst) begin
                mN = 0;
                for (int i = 0; i < 4; i++) mDig[i] = 7'h00;
                mMode = 2'b00;
                mDp   = 1'b0;
            end else begin
                if (mN % FRAME == FRAME - 1) begin
                    for (int i = 0; i < 4; i++) mDig[i] = digIn[i];
                    mMode = modo;
                    mDp   = dpEn;
                end
                mN++;
            end
            @(posedge clk);
            #1;
            got = {an, seg, dp};
            checkOutput($sformatf("scan@%0d", mN), got, expQ.pop_front());
            checkOutput("an_onehot", 12'($countones(~an) <= 1), 12'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mDig[i] = 7'h00;
        digIn[0] = PAT1;
        digIn[1] = PAT2;
        digIn[2] = PAT3;
        digIn[3] = PAT4;
        modo     = 2'b00;
        dpEn     = 1'b0;
        rst      = 1'b0;
        applyStimulus(3);
        checkOutput("reset_an", 12'(an), 12'hF);
        checkOutput("reset_seg", 12'(seg), 12'h7F);
        checkOutput("reset_dp", 12'(dp), 12'h1);

        rst = 1'b1;
        applyStimulus(FRAME + 4);
        digIn[1] = PAT7;
        applyStimulus(FRAME * 2 - 4);

        modo = 2'b01;
        applyStimulus(FRAME * 8);

        modo     = 2'b10;
        digIn[3] = SEG_ZERO;
        applyStimulus(FRAME * 8);
        modo = 2'b00;
        applyStimulus(FRAME * 4);
        modo = 2'b11;
        applyStimulus(FRAME * 2);

        modo     = 2'b00;
        digIn[3] = PAT4;
        dpEn     = 1'b1;
        applyStimulus(FRAME * 3);

        for (int k = 0; k < FRAME && (mN % FRAME) != 9; k++) applyStimulus(1);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("midreset_an", 12'(an), 12'hF);
        checkOutput("midreset_seg", 12'(seg), 12'h7F);
        rst = 1'b1;
        applyStimulus(FRAME * 3);

        repeat (4) begin
            for (int i = 0; i < 4; i++) digIn[i] = 7'($urandom_range(0, 127));
            modo = 2'($urandom_range(0, 3));
            dpEn = 1'($urandom_range(0, 1));
            applyStimulus(FRAME * 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan.md
# display_scan

Downstream stage of the clock core: takes the four decoded 7-segment digit patterns plus the current mode, and time-multiplexes them onto one shared segment bus with per-digit enables. It also blinks the field being edited, blanks a leading hour zero, and drives the colon dot. It removes the need for four dedicated segment buses on multiplexed display boards.

## Interface
- REFRESH_DIV, 1000: clock cycles per digit slot; must be ≥ DEAD+2.
- DEAD, 2: cycles at the start of each slot during which all enables are off, for ghosting suppression.
- BLINK_FRAMES, 125: full scan frames per blink half-period; must be ≥ 1.
- SEG_ACTIVE_LOW, 1: invert seg and dp at the output.
- AN_ACTIVE_LOW, 1: invert an at the output.
- LZ_BLANK, 1: enable leading-zero blanking of digit 3.
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- dig0, dig1, dig2, dig3  input  7 each  segment patterns abcdefg (bit6=a, bit0=g), active-high; dig0 = minute units, dig3 = hour tens.
- modo  input  2  00 running, 01 set minutes, 10 set hours, 11 treated as 00.
- dp_en  input  1  colon request.
- seg  output  7  shared segment bus.
- dp  output  1  decimal point, lit only in digit 2's slot.
- an  output  4  one-hot digit enable; bit i selects digit i.

## Operation
- Scan counters:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At its terminal count, idx advances 0→1→2→3→0.
  - A frame is 4·REFRESH_DIV cycles.
- Shadow capture:
  - On the cycle where div_cnt = REFRESH_DIV-1 and idx = 3, dig0..3, modo and dp_en are captured into shadow registers.
  - All display decisions use the shadow values only, so the display never tears mid-frame.
- Blink:
  - frame_cnt counts completed frames 0..BLINK_FRAMES-1.
  - At its wrap, blink_ph toggles.
  - When blink_ph = 1 and shadow mode = 01, digits 0 and 1 are blanked. When shadow mode = 10, digits 2 and 3 are blanked.
  - Blanked means seg all off while an still asserts normally.
- Leading zero:
  - Applies when LZ_BLANK = 1, shadow dig3 = 7'b1111110 and shadow mode ≠ 10.
  - Digit 3's segments are then blanked.
- dp is on only when idx = 2, shadow dp_en = 1, and the enable is active.
- Enable: an = one-hot(idx) when div_cnt ≥ DEAD, otherwise all off.
- Polarity inversion is applied last, after all blanking.

## Timing
- All outputs are registered. seg, dp and an at edge t+1 reflect div_cnt, idx and the shadow registers at edge t.
- Reset (rst = 0 at an edge) clears div_cnt, idx, frame_cnt and blink_ph to 0, and clears the shadow registers to 0. The shadow clear yields a blank frame and mode 00.
- Output reset values are all inactive: an = 4'b1111, seg = 7'h7F and dp = 1 with the default active-low parameters (0s if both polarity parameters are 0).
- A reset mid-frame aborts the frame. Outputs are inactive on the edge after reset is sampled.
- The first captured values appear in the frame starting REFRESH_DIV·4 cycles after reset release. Frame 0 is blank.
- Input change mid-frame is ignored until the next capture edge.
- A modo change lands at the frame boundary. blink_ph is not reset by a mode change.
- Capture and blink toggle on the same cycle: the new frame uses the new mode with the toggled phase.
- an never has more than one bit active. Every slot has exactly DEAD cycles of all-off enable.

## Structure
- Package display_pkg holds:
  - MODE_RUN = 2'b00, MODE_SET_MIN = 2'b01, MODE_SET_HORA = 2'b10.
  - SEG_BLANK = 7'h00, SEG_ZERO = 7'b1111110.
  - typedef for the 2-bit mode.
- Sub-module scan_timer (div_cnt, idx, frame_cnt, blink_ph, with slot/frame-end strobes). The top level holds the shadow registers, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_DIV=4, DEAD=1, BLINK_FRAMES=2, active-low defaults.

- Reset hold then release with dig0..3 = 1,2,3,4 patterns and modo=00:
  - Frame 0: an cycles 1110/1101/1011/0111 with seg = 7'h7F.
  - Frame 1: seg = ~dig0..~dig3 in order.
  - First cycle of each slot: an = 4'b1111.
- Change dig1 mid-frame 1 → new value appears only in frame 2's digit-1 slot.
- modo=01 → digits 0 and 1 show seg = 7'h7F for 2 frames, then their patterns for 2 frames, repeating. Digits 2 and 3 are unaffected.
- modo=10 with dig3 = SEG_ZERO → digit 3 shows the zero pattern and blinks (no leading-zero blank). With modo=00, digit 3 is always 7'h7F.
- dp_en=1 → dp = 0 only during digit-2 active cycles; dp = 1 during DEAD cycles and other slots.
- Assert rst for one cycle mid digit-2 slot → next edge: an = 4'b1111, seg = 7'h7F. The following frame is blank, then normal display resumes.
